// File: rtl/lag_tracker.sv
`timescale 1ns/1ps
// lag_tracker: smooths per-frame microphone lag estimates with a moving
// average, applies hysteresis to the published average and maps it to a
// horizontal screen coordinate for the overlay. Single clock domain.
module lag_tracker #(
  parameter int LAGNUM      = 10,
  parameter int AVG_LOG2    = 2,
  parameter int HYST        = 2,
  parameter int X_CENTER    = 640,
  parameter int X_STEP      = 32,
  parameter int X_MAX       = 1279,
  parameter int X_W         = 11,
  parameter int TIMEOUT_CYC = 60000000
) (
  input  logic                clk_60MHz,
  input  logic                rst_n,
  input  logic signed [5:0]   lag_in,
  input  logic                lag_valid,
  output logic                lag_ready,
  input  logic                clear_ovr,
  output logic [X_W-1:0]      pos_x,
  output logic signed [5:0]   pos_avg,
  output logic                pos_valid,
  output logic                locked,
  output logic                pos_stale,
  output logic                overrun
);

  localparam int D      = 1 << AVG_LOG2;
  localparam int SUM_W  = 6 + AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UPDATE  = 2'd1,
    COMPARE = 2'd2,
    MAP     = 2'd3
  } state_e;

  // Limit an incoming lag to the physically meaningful range.
  function automatic logic signed [5:0] clamp_lag(input logic signed [5:0] v);
    if (int'(v) > LAGNUM)
      return 6'(LAGNUM);
    else if (int'(v) < -LAGNUM)
      return 6'(-LAGNUM);
    else
      return v;
  endfunction

  // Lag -> screen x, computed in 32-bit signed so the product cannot wrap,
  // then saturated to the visible range.
  function automatic logic [X_W-1:0] map_x(input logic signed [5:0] a);
    int x;
    x = X_CENTER + int'(a) * X_STEP;
    if (x < 0)
      return '0;
    else if (x > X_MAX)
      return X_W'(X_MAX);
    else
      return X_W'(x);
  endfunction

  // True when the new average has moved far enough from the published one.
  function automatic logic hyst_exceeded(input logic signed [5:0] a,
                                         input logic signed [5:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = -d;
    return (d >= HYST);
  endfunction

  state_e                    state_q, state_d;
  logic signed [5:0]         lag_q, lag_d;
  logic signed [5:0]         hist_q [D];
  logic signed [5:0]         hist_d [D];
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [PTR_W-1:0]          wp_q, wp_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic                      published_q, published_d;
  logic signed [5:0]         avg_q, avg_d;
  logic                      pub_q, pub_d;
  logic [X_W-1:0]            pos_x_q, pos_x_d;
  logic signed [5:0]         pos_avg_q, pos_avg_d;
  logic                      pos_valid_q, pos_valid_d;
  logic                      locked_q, locked_d;
  logic                      stale_q, stale_d;
  logic                      ovr_q, ovr_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;

  logic signed [SUM_W-1:0]   lag_ext;
  logic signed [SUM_W-1:0]   old_ext;
  logic signed [SUM_W-1:0]   sum_shr;
  logic [FILL_W-1:0]         fill_inc;

  // Sign-extended operands for the running-sum update and the floor average.
  always_comb begin
    lag_ext  = SUM_W'(lag_q);
    old_ext  = SUM_W'(hist_q[wp_q]);
    sum_shr  = sum_q >>> AVG_LOG2;
    fill_inc = (fill_q == FILL_W'(D)) ? fill_q : fill_q + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_60MHz) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state, datapath next values, timeout and overrun handling.
  always_comb begin
    state_d     = state_q;
    lag_d       = lag_q;
    hist_d      = hist_q;
    sum_d       = sum_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    published_d = published_q;
    avg_d       = avg_q;
    pub_d       = pub_q;
    pos_x_d     = pos_x_q;
    pos_avg_d   = pos_avg_q;
    pos_valid_d = 1'b0;
    locked_d    = locked_q;
    stale_d     = stale_q;
    to_cnt_d    = to_cnt_q;

    // A strobe while busy is dropped; setting beats clearing.
    ovr_d = ovr_q;
    if (lag_valid && (state_q != IDLE))
      ovr_d = 1'b1;
    else if (clear_ovr)
      ovr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lag_valid) begin
          lag_d    = clamp_lag(lag_in);
          to_cnt_d = '0;
          stale_d  = 1'b0;
          state_d  = UPDATE;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
          to_cnt_d = to_cnt_q + 1'b1;
          // Source has gone quiet: forget history but keep last position.
          if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            stale_d     = 1'b1;
            locked_d    = 1'b0;
            sum_d       = '0;
            wp_d        = '0;
            fill_d      = '0;
            published_d = 1'b0;
            for (int i = 0; i < D; i++) hist_d[i] = '0;
          end
        end
      end
      UPDATE: begin
        sum_d        = sum_q - old_ext + lag_ext;
        hist_d[wp_q] = lag_q;
        wp_d         = (wp_q == PTR_W'(D - 1)) ? '0 : wp_q + 1'b1;
        fill_d       = fill_inc;
        if (fill_inc == FILL_W'(D))
          locked_d = 1'b1;
        state_d = COMPARE;
      end
      COMPARE: begin
        avg_d   = sum_shr[5:0];
        pub_d   = locked_q && (!published_q || hyst_exceeded(sum_shr[5:0], pos_avg_q));
        state_d = MAP;
      end
      MAP: begin
        if (pub_q) begin
          pos_x_d     = map_x(avg_q);
          pos_avg_d   = avg_q;
          published_d = 1'b1;
          pos_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status registers; everything returns to a known state on reset.
  always_ff @(posedge clk_60MHz) begin
    if (!rst_n) begin
      lag_q       <= '0;
      hist_q      <= '{default: '0};
      sum_q       <= '0;
      wp_q        <= '0;
      fill_q      <= '0;
      published_q <= 1'b0;
      avg_q       <= '0;
      pub_q       <= 1'b0;
      pos_x_q     <= X_W'(X_CENTER);
      pos_avg_q   <= '0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      stale_q     <= 1'b0;
      ovr_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      lag_q       <= lag_d;
      hist_q      <= hist_d;
      sum_q       <= sum_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      published_q <= published_d;
      avg_q       <= avg_d;
      pub_q       <= pub_d;
      pos_x_q     <= pos_x_d;
      pos_avg_q   <= pos_avg_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      stale_q     <= stale_d;
      ovr_q       <= ovr_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign lag_ready = (state_q == IDLE);
  assign pos_x     = pos_x_q;
  assign pos_avg   = pos_avg_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign pos_stale = stale_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_lag_tracker.sv
`timescale 1ns/1ps
// Self-checking bench for lag_tracker. Two instances share all inputs and
// differ only in X_STEP so that both clamp edges of pos_x are reachable.
module tb_lag_tracker;

  localparam int LAGNUM = 10;
  localparam int D      = 4;
  localparam int HYST   = 2;
  localparam int XC     = 640;
  localparam int XMAX   = 1279;
  localparam int TO     = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic signed [5:0] lag_in = '0;
  logic              lag_valid = 1'b0;
  logic              clear_ovr = 1'b0;

  logic              lag_ready, pos_valid, locked, pos_stale, overrun;
  logic [10:0]       pos_x;
  logic signed [5:0] pos_avg;
  logic              lag_ready_b, pos_valid_b, locked_b, pos_stale_b, overrun_b;
  logic [10:0]       pos_x_b;
  logic signed [5:0] pos_avg_b;

  lag_tracker #(.LAGNUM(LAGNUM), .AVG_LOG2(2), .HYST(HYST), .X_CENTER(XC),
                .X_STEP(32), .X_MAX(XMAX), .X_W(11), .TIMEOUT_CYC(TO)) dut_a (
    .clk_60MHz(clk), .rst_n(rst_n), .lag_in(lag_in), .lag_valid(lag_valid),
    .lag_ready(lag_ready), .clear_ovr(clear_ovr), .pos_x(pos_x), .pos_avg(pos_avg),
    .pos_valid(pos_valid), .locked(locked), .pos_stale(pos_stale), .overrun(overrun));

  lag_tracker #(.LAGNUM(LAGNUM), .AVG_LOG2(2), .HYST(HYST), .X_CENTER(XC),
                .X_STEP(100), .X_MAX(XMAX), .X_W(11), .TIMEOUT_CYC(TO)) dut_b (
    .clk_60MHz(clk), .rst_n(rst_n), .lag_in(lag_in), .lag_valid(lag_valid),
    .lag_ready(lag_ready_b), .clear_ovr(clear_ovr), .pos_x(pos_x_b), .pos_avg(pos_avg_b),
    .pos_valid(pos_valid_b), .locked(locked_b), .pos_stale(pos_stale_b), .overrun(overrun_b));

  typedef struct {
    logic signed [5:0] avg;
    logic [10:0]       xa;
    logic [10:0]       xb;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state
  int m_hist[D];
  int m_wp, m_fill, m_last_xa;
  bit m_pub;
  int m_last_avg;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int floor_div(input int s);
    return (s >= 0) ? s / D : -((-s + D - 1) / D);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_hist[i] = 0;
    m_wp = 0; m_fill = 0; m_pub = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_last_avg = 0; m_last_xa = XC;
    sb_q.delete();
  endtask

  task automatic model_accept(input int lag);
    int s, a, d;
    exp_t e;
    m_hist[m_wp] = clampi(lag, -LAGNUM, LAGNUM);
    m_wp = (m_wp + 1) % D;
    if (m_fill < D) m_fill++;
    if (m_fill == D) begin
      s = 0;
      for (int i = 0; i < D; i++) s += m_hist[i];
      a = floor_div(s);
      d = (a > m_last_avg) ? a - m_last_avg : m_last_avg - a;
      if (!m_pub || d >= HYST) begin
        e.avg = 6'(a);
        e.xa  = 11'(clampi(XC + a * 32, 0, XMAX));
        e.xb  = 11'(clampi(XC + a * 100, 0, XMAX));
        sb_q.push_back(e);
        m_pub = 1; m_last_avg = a; m_last_xa = XC + a * 32;
      end
    end
  endtask

  // Scoreboard consumer: every pos_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && pos_valid) begin
      exp_t e;
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pos_valid got pos_avg=%0d pos_x=%0d, required no pulse", pos_avg, pos_x);
      end else begin
        e = sb_q.pop_front();
        if (pos_avg !== e.avg || pos_x !== e.xa || pos_x_b !== e.xb ||
            pos_avg_b !== e.avg || pos_valid_b !== 1'b1) begin
          n_fail++;
          $display("FAIL pos_pulse got avg=%0d x=%0d xb=%0d vb=%b, required avg=%0d x=%0d xb=%0d vb=1",
                   pos_avg, pos_x, pos_x_b, pos_valid_b, e.avg, e.xa, e.xb);
        end
      end
    end
  end

  task automatic drive_accept(input int lag);
    int w;
    w = 0;
    @(negedge clk);
    while (!lag_ready && w < 10) begin @(negedge clk); w++; end
    n_chk++;
    if (lag_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait got lag_ready=%b, required 1", lag_ready);
    end
    lag_in = 6'(lag); lag_valid = 1'b1;
    @(negedge clk);
    lag_valid = 1'b0;
    model_accept(lag);
  endtask

  task automatic send_lag(input int lag);
    drive_accept(lag);
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pos_valid got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lag_valid = 1'b0; clear_ovr = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({lag_ready, pos_valid, locked, pos_stale, overrun} !== 5'b10000 ||
        {lag_ready_b, pos_valid_b, locked_b, pos_stale_b, overrun_b} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got %b/%b, required 10000",
               {lag_ready, pos_valid, locked, pos_stale, overrun},
               {lag_ready_b, pos_valid_b, locked_b, pos_stale_b, overrun_b});
    end
    n_chk++;
    if (pos_x !== 11'd640 || pos_x_b !== 11'd640) begin
      n_fail++;
      $display("FAIL reset_pos_x got %0d/%0d, required 640", pos_x, pos_x_b);
    end
    n_chk++;
    if (pos_avg !== 6'sd0) begin
      n_fail++;
      $display("FAIL reset_pos_avg got %0d, required 0", pos_avg);
    end
  endtask

  task automatic test_fill_lock();
    for (int i = 0; i < 4; i++) begin
      send_lag(3);
      n_chk++;
      if (locked !== (i == 3)) begin
        n_fail++;
        $display("FAIL lock_%0d got locked=%b, required %b", i, locked, (i == 3));
      end
    end
    n_chk++;
    if (pos_avg !== 6'sd3 || pos_x !== 11'd736) begin
      n_fail++;
      $display("FAIL lock_pos got avg=%0d x=%0d, required avg=3 x=736", pos_avg, pos_x);
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 4; i++) begin
      send_lag(7);
      if (i == 1) begin
        n_chk++;
        if (pos_avg !== 6'sd5 || pos_x !== 11'd800) begin
          n_fail++;
          $display("FAIL hyst_mid got avg=%0d x=%0d, required avg=5 x=800", pos_avg, pos_x);
        end
      end
    end
    n_chk++;
    if (pos_avg !== 6'sd7 || pos_x !== 11'd864) begin
      n_fail++;
      $display("FAIL hyst_end got avg=%0d x=%0d, required avg=7 x=864", pos_avg, pos_x);
    end
  endtask

  task automatic test_clamp_floor();
    do_reset();
    for (int i = 0; i < 4; i++) send_lag(31);
    n_chk++;
    if (pos_avg !== 6'sd10 || pos_x !== 11'd960 || pos_x_b !== 11'd1279) begin
      n_fail++;
      $display("FAIL clamp_hi got avg=%0d x=%0d xb=%0d, required 10/960/1279", pos_avg, pos_x, pos_x_b);
    end
    for (int i = 0; i < 4; i++) send_lag(-31);
    n_chk++;
    if (pos_avg !== -6'sd10 || pos_x !== 11'd320 || pos_x_b !== 11'd0) begin
      n_fail++;
      $display("FAIL clamp_lo got avg=%0d x=%0d xb=%0d, required -10/320/0", pos_avg, pos_x, pos_x_b);
    end
    send_lag(0); send_lag(0); send_lag(0); send_lag(-3);
    n_chk++;
    if (pos_avg !== -6'sd1 || pos_x !== 11'd608) begin
      n_fail++;
      $display("FAIL floor_avg got avg=%0d x=%0d, required -1/608", pos_avg, pos_x);
    end
  endtask

  task automatic test_overrun();
    drive_accept(0);
    n_chk++;
    if (lag_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready got %b, required 0", lag_ready);
    end
    lag_in = 6'sd31; lag_valid = 1'b1;
    @(negedge clk);
    lag_valid = 1'b0;
    n_chk++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set got %b, required 1", overrun);
    end
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovr_missing_pos_valid got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    n_chk++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear got %b, required 0", overrun);
    end
    drive_accept(0);
    lag_in = -6'sd31; lag_valid = 1'b1; clear_ovr = 1'b1;
    @(negedge clk);
    lag_valid = 1'b0; clear_ovr = 1'b0;
    n_chk++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins got %b, required 1", overrun);
    end
    repeat (2) @(negedge clk);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    // Dropped samples must not have disturbed the average.
    send_lag(0);
    n_chk++;
    if (overrun !== 1'b0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_after got ovr=%b locked=%b, required 0/1", overrun, locked);
    end
  endtask

  task automatic test_timeout();
    int w;
    send_lag(0);
    repeat (990) @(negedge clk);
    n_chk++;
    if (pos_stale !== 1'b0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL early_stale got stale=%b locked=%b, required 0/1", pos_stale, locked);
    end
    w = 0;
    while (!pos_stale && w < 40) begin @(negedge clk); w++; end
    n_chk++;
    if (pos_stale !== 1'b1 || w != 10) begin
      n_fail++;
      $display("FAIL stale_timing got stale=%b after %0d more cycles, required 1 after 10", pos_stale, w);
    end
    n_chk++;
    if (locked !== 1'b0 || pos_x !== 11'(m_last_xa)) begin
      n_fail++;
      $display("FAIL stale_state got locked=%b x=%0d, required 0/%0d", locked, pos_x, m_last_xa);
    end
    model_clear();
    send_lag(5);
    n_chk++;
    if (pos_stale !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_recover got stale=%b locked=%b, required 0/0", pos_stale, locked);
    end
  endtask

  task automatic test_reset_midop();
    send_lag(2); send_lag(2); send_lag(2);
    @(negedge clk);
    lag_in = 6'sd10; lag_valid = 1'b1;
    @(negedge clk);
    lag_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({lag_ready, pos_valid, locked, pos_stale, overrun} !== 5'b10000 ||
        pos_x !== 11'd640 || pos_avg !== 6'sd0) begin
      n_fail++;
      $display("FAIL midop_reset got flags=%b x=%0d avg=%0d, required 10000/640/0",
               {lag_ready, pos_valid, locked, pos_stale, overrun}, pos_x, pos_avg);
    end
    model_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_chk++;
    if (pos_x !== 11'd640 || lag_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_after got x=%0d ready=%b, required 640/1", pos_x, lag_ready);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_lock();
    test_hysteresis();
    test_clamp_floor();
    test_overrun();
    test_timeout();
    test_reset_midop();
    repeat (5) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending got %0d, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
